// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder data-memory slave.
// Access-size encodings, FSM states, MMIO address and the captured request layout.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSV  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        size_e       size;
        logic        uns;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane steering: store byte enables / data replication and load
// lane extraction with sign or zero extension.
module dmem_lane_ctrl
    import dmem_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte   = rword_i[{addr_lo_i, 3'b000} +: 8];
        rhalf   = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = rword_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{rbyte[7] & ~uns_i}}, rbyte};
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{rhalf[15] & ~uns_i}}, rhalf};
            end
            SZ_WORD: be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed wait states.
// Optional read-only cycle counter at MMIO_ADDR when DMEM_MMIO_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Req,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic        Ready,
    output logic [31:0] ReadData,
    output logic        Fault
);

    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_M1 = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    dmem_req_t   req_q, cur;
    logic        fault_q, fault_c, misalign, oor, mmio_hit;
    logic [31:0] rdata_q, rdata_d, rword, wd_al, rd_ext;
    logic [3:0]  be;
    logic        enter_resp, commit;
    logic [IDX_W-1:0] idx;
    logic [31:0] mem [DEPTH_WORDS];

    // In IDLE the live inputs drive decode so a zero-wait or faulting access
    // can be resolved on its accept edge; afterwards only the captured copy counts.
    always_comb begin
        if (state_q == IDLE)
            cur = '{we: MemWrite, addr: Addr, wdata: WriteData,
                    size: size_e'(Size), uns: Unsigned};
        else
            cur = req_q;
    end

    assign idx = cur.addr[IDX_W+1:2];
    assign oor = |(cur.addr >> (IDX_W + 2));

`ifdef DMEM_MMIO_EN
    logic [31:0] cnt_q;
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) cnt_q <= '0;
        else        cnt_q <= cnt_q + 32'd1;
    end
    assign mmio_hit = (cur.addr == MMIO_ADDR);
    assign rword    = mmio_hit ? cnt_q : mem[idx];
`else
    assign mmio_hit = 1'b0;
    assign rword    = mem[idx];
`endif

    always_comb begin
        case (cur.size)
            SZ_HALF: misalign = cur.addr[0];
            SZ_WORD: misalign = |cur.addr[1:0];
            SZ_RSV:  misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
        fault_c = misalign | (oor & ~mmio_hit);
    end

    dmem_lane_ctrl u_lane (
        .size_i    (cur.size),
        .addr_lo_i (cur.addr[1:0]),
        .uns_i     (cur.uns),
        .wdata_i   (cur.wdata),
        .rword_i   (rword),
        .be_o      (be),
        .wdata_o   (wd_al),
        .rdata_o   (rd_ext)
    );

    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    assign commit     = enter_resp & cur.we & ~fault_c & ~mmio_hit;
    assign rdata_d    = (fault_c | cur.we) ? '0 : rd_ext;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            req_q   <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (state_q == IDLE && Req) req_q <= cur;
            if (enter_resp) begin
                fault_q <= fault_c;
                rdata_q <= rdata_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: if (Req) begin
                if (fault_c || WAIT_STATES == 0) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    wcnt_d  = WS_M1;
                end
            end
            WAIT: if (wcnt_q == 4'd0) state_d = RESP;
                  else                wcnt_d  = wcnt_q - 4'd1;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Ready    = (state_q == RESP);
        ReadData = Ready ? rdata_q : '0;
        Fault    = Ready & fault_q;
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (commit) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wd_al[8*b +: 8];
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, giving the wait cycles between accept and response (0..15).
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Req  input  1  request valid from the core.
REQ-006 SHALL have port MemWrite  input  1  1 = store, 0 = load.
REQ-007 SHALL have port Addr  input  32  byte address (core ALUResult).
REQ-008 SHALL have port WriteData  input  32  store data, right-aligned.
REQ-009 SHALL have port Size  input  2  access size: 00 byte, 01 halfword, 10 word (11 reserved).
REQ-010 SHALL have port Unsigned  input  1  1 = zero-extend loads, 0 = sign-extend loads.
REQ-011 SHALL have port Ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port ReadData  output  32  extended load data, valid while Ready=1.
REQ-013 SHALL have port Fault  output  1  access error, valid while Ready=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 SHALL, in IDLE with Req=1, capture MemWrite, Addr, WriteData, Size and Unsigned (the accept edge).
REQ-016 SHALL treat input changes after the accept edge as ignored until the state returns to IDLE.
REQ-017 SHALL, after accept, go to WAIT for exactly WAIT_STATES cycles, or directly to RESP when WAIT_STATES=0.
REQ-018 SHALL hold Ready=1 for exactly one cycle, in RESP, then return to IDLE.
REQ-019 SHALL give a Req-to-Ready latency of WAIT_STATES+1 cycles after the accept edge.
REQ-020 SHALL accept the next request no earlier than the cycle after RESP.
REQ-021 SHALL complete an accepted transaction even if Req drops before Ready.
REQ-022 SHALL flag a fault when any of these holds:
- halfword access with Addr[0]=1;
- word access with Addr[1:0]!=00;
- Size=11;
- Addr >= DEPTH_WORDS*4, excluding the MMIO address when enabled.
REQ-023 SHALL, on a fault, go straight to RESP with Fault=1 and ReadData=0, skip the wait states, and leave storage unmodified.
REQ-024 SHALL commit stores on the edge that enters RESP.
REQ-025 SHALL write stores through byte enables: byte lane Addr[1:0], halfword lanes Addr[1]; unselected bytes are unchanged.
REQ-026 SHALL, for loads, select the addressed byte or halfword and sign- or zero-extend it to 32 bits per Unsigned.
REQ-027 SHALL hold ReadData=0 and Fault=0 whenever Ready=0.

Reset
REQ-028 SHALL, while Reset=0, force state IDLE, Ready=0, ReadData=0, Fault=0 and clear the captured request registers, regardless of clock.
REQ-029 SHALL drop a store whose reset arrives before the RESP-entry edge, leaving storage unmodified.
REQ-030 SHALL NOT reset storage contents; they are undefined after power-up.

Configuration
REQ-031 SHALL, with macro DMEM_MMIO_EN defined, map Addr 0xFFFF_FFF0 to a read-only 32-bit free-running cycle counter.
REQ-032 SHALL, with DMEM_MMIO_EN defined, clear the counter to 0 on reset, increment it every CLK and let it wrap at 2^32-1.
REQ-033 SHALL, with DMEM_MMIO_EN defined, return the counter value sampled on the RESP-entry edge for a word load at 0xFFFF_FFF0.
REQ-034 SHALL, with DMEM_MMIO_EN defined, ignore stores to 0xFFFF_FFF0 without setting Fault.
REQ-035 SHALL, without DMEM_MMIO_EN, omit the counter entirely and treat 0xFFFF_FFF0 as out of range (Fault=1).

Structure
REQ-036 SHALL take the Size encodings, the FSM state enum and the MMIO address constant from shared package dmem_pkg.
REQ-037 SHALL place byte-enable generation and load lane-extraction/extension in one combinational sub-module, dmem_lane_ctrl.

Verification
REQ-038 SHALL cover a word store then a load: store 0xDEADBEEF at 0x10, then load word 0x10, with WAIT_STATES=1 -> Ready 2 cycles after each accept, ReadData=0xDEADBEEF, Fault=0.
REQ-039 SHALL cover byte loads: over word 0xDEADBEEF, load byte at 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE.
REQ-040 SHALL cover a halfword store at 0x12 with data 0x1234 -> a word load at 0x10 returns 0x1234BEEF.
REQ-041 SHALL cover faults: word load at 0x11 -> Ready 1 cycle after accept with Fault=1; word store at 0x1000 (DEPTH_WORDS=1024) -> Fault=1 and memory unchanged.
REQ-042 SHALL cover reset mid-store: Reset=0 during WAIT of a store of 0x55 at 0x20 -> Ready never pulses, Ready=0 immediately, and old contents are preserved.
REQ-043 SHALL cover MMIO with DMEM_MMIO_EN: two word loads of 0xFFFF_FFF0 accepted 10 cycles apart -> values differ by 10; without the macro -> Fault=1.
